// File: rtl/fib_stream_checker.sv
// Receive-side checker for the 8-bit enable-gated Fibonacci stream.
// It keeps a private copy of the generator state pair (ea, eb) and compares
// every incoming sample against it. Lock is dropped after a run of consecutive
// misses and is re-acquired from two advancing samples.
//
// state  | meaning
// -------+----------------------------------------------------------------
// HUNT   | no valid model; waiting for the first advancing sample
// SEED   | first term captured in p; waiting for the next advancing sample
// LOCKED | model valid; every sample is checked and the model tracks adv
module fib_stream_checker #(
   parameter bit          START_LOCKED = 1'b1,
   parameter int unsigned LOSS_THRESH  = 4,
   parameter int unsigned ERR_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic [7:0]       data,
   output logic             locked,
   output logic             mismatch,
   output logic [7:0]       exp_data,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SEED   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam state_t     RST_STATE = START_LOCKED ? LOCKED : HUNT;
   localparam logic [3:0] THRESH    = 4'(LOSS_THRESH);

   state_t           state, state_nxt;
   logic [7:0]       ea, ea_nxt;
   logic [7:0]       eb, eb_nxt;
   logic [7:0]       p, p_nxt;
   logic [3:0]       miss, miss_nxt;
   logic             mismatch_nxt;
   logic [7:0]       exp_nxt;
   logic [ERR_W-1:0] err_nxt;

   logic [7:0]       expected;
   logic [3:0]       miss_inc;

   assign expected = adv ? eb : ea;
   assign miss_inc = miss + 4'd1;
   assign locked   = (state == LOCKED);

   // Register update; reset wins over whatever the sample would have done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_STATE;
         ea        <= 8'h00;
         eb        <= 8'h01;
         p         <= 8'h00;
         miss      <= 4'd0;
         mismatch  <= 1'b0;
         exp_data  <= 8'h00;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         ea        <= ea_nxt;
         eb        <= eb_nxt;
         p         <= p_nxt;
         miss      <= miss_nxt;
         mismatch  <= mismatch_nxt;
         exp_data  <= exp_nxt;
         err_count <= err_nxt;
      end
   end

   // Next-state, model update and check result for this cycle's sample.
   always_comb begin
      state_nxt    = state;
      ea_nxt       = ea;
      eb_nxt       = eb;
      p_nxt        = p;
      miss_nxt     = miss;
      mismatch_nxt = 1'b0;
      exp_nxt      = 8'h00;
      err_nxt      = err_count;

      case (state)
         HUNT: begin
            if (adv) begin
               p_nxt     = data;
               state_nxt = SEED;
            end
         end

         SEED: begin
            if (adv) begin
               // The second seed sample rebuilds the pair; it is not itself checked.
               ea_nxt    = data;
               eb_nxt    = p + data;
               miss_nxt  = 4'd0;
               state_nxt = LOCKED;
            end else if (data != p) begin
               state_nxt = HUNT;
            end
         end

         LOCKED: begin
            exp_nxt = expected;
            if (adv) begin
               // Model follows the strobe even on a bad sample so a single
               // corrupted byte does not desynchronise the following terms.
               ea_nxt = eb;
               eb_nxt = ea + eb;
            end
            if (data == expected) begin
               miss_nxt = 4'd0;
            end else begin
               mismatch_nxt = 1'b1;
               miss_nxt     = miss_inc;
               if (err_count != '1) begin
                  err_nxt = err_count + ERR_W'(1);
               end
               if (miss_inc == THRESH) begin
                  state_nxt = HUNT;
               end
            end
         end

         default: begin
            state_nxt = HUNT;
         end
      endcase
   end

endmodule

// File: doc/fib_stream_checker.md
# fib_stream_checker

Receive-side checker for the 8-bit Fibonacci stream produced by the enable-gated generator top level (state pair reset to (0x00, 0x01); each advance outputs the next term, idle cycles repeat the last term). The checker sits on the far end of that link. It samples the advance strobe and data byte every cycle and keeps its own copy of the generator state. It flags every sample that disagrees with that copy, counts errors, and drops and re-acquires lock when the stream is lost.

## Interface
- `START_LOCKED`, default 1: 1 = leave reset LOCKED with model (0x00, 0x01); 0 = leave reset in HUNT.
- `LOSS_THRESH`, default 4: number of consecutive LOCKED mismatches that forces HUNT. Legal range 1..15.
- `ERR_W`, default 16: width of the error counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `adv`  in  1  generator advance strobe for this cycle's sample.
- `data`  in  8  generator output byte for this cycle.
- `locked`  out  1  checker model is valid.
- `mismatch`  out  1  one-cycle pulse: the previous cycle's sample was wrong while LOCKED.
- `exp_data`  out  8  expected byte for the previous cycle's sample. Holds 0x00 outside LOCKED.
- `err_count`  out  ERR_W  saturating count of LOCKED mismatches.

## Operation
- Model registers `ea` and `eb` (8 bits each) mirror the generator state. All sums are mod 256: drop the carry, no saturation.
- States: HUNT, SEED, LOCKED. Register `p` (8 bits) and consecutive-miss counter `miss` (4 bits).
- The expected byte each cycle is `adv ? eb : ea`.
- HUNT:
  - If `adv`=1: `p`<=`data`, go to SEED.
  - Otherwise stay in HUNT.
- SEED:
  - If `adv`=1: `ea`<=`data`, `eb`<=`p`+`data`, `miss`<=0, go to LOCKED.
  - If `adv`=0 and `data`==`p`: stay in SEED.
  - If `adv`=0 and `data`!=`p`: go to HUNT.
- LOCKED, every cycle:
  - `mismatch`<=(`data`!=expected).
  - `exp_data`<=expected.
  - On `adv`, the model advances: (`ea`,`eb`)<=(`eb`,`ea`+`eb`). This happens whether or not the sample matched.
  - On a match, `miss`<=0.
  - On a mismatch, `err_count` increments (it sticks at all-ones) and `miss` increments.
  - If `miss`+1==`LOSS_THRESH`: go to HUNT, and `locked` falls on the same edge. The `mismatch` pulse and the `err_count` increment for that sample still occur.
- HUNT and SEED never assert `mismatch` and never change `err_count`.
- `err_count` clears only on `rst`.

## Timing
- All outputs are registered. A sample presented in cycle N produces `mismatch`/`exp_data` in cycle N+1.
- `locked` rises on the edge that consumes the second seed sample. That seed sample itself is not checked. The first checked sample is the following cycle's.
- Minimum re-acquisition: 2 advancing cycles after entering HUNT.
- Reset values:
  - `locked`=`START_LOCKED`, `mismatch`=0, `exp_data`=0x00, `err_count`=0.
  - `ea`=0x00, `eb`=0x01, `p`=0x00, `miss`=0.
  - State = LOCKED if `START_LOCKED`=1, else HUNT.
- `rst` in mid-stream overrides every transition in that cycle, and the sample of that cycle is discarded.
- No backpressure: one sample is consumed every cycle.

## Test plan
- Reset-aligned run (`START_LOCKED`=1), `adv`=1 for 16 cycles with data 1,1,2,3,5,8,13,21,34,55,89,144,233,121,98,219 → `mismatch` never asserts, `err_count`=0, last `exp_data`=219 (wrap-around path covered).
- Idle interleave: after data 1,1,2 with `adv`=1, drive `adv`=0 with data=2 for 3 cycles, then `adv`=1 data=3 → no mismatch, `exp_data`=2 during the idle cycles, then 3.
- Single corruption: in a locked run, replace the term 8 with 0x09 → exactly one `mismatch` pulse, `err_count`=1, the next term 13 is accepted, `miss` returns to 0.
- Loss: with `LOSS_THRESH`=4, drive data 0xFF with `adv`=1 for 4 cycles → 4 pulses, `err_count`=4, `locked` falls one cycle after the 4th sample, no further pulses.
- Re-acquire: from HUNT, drive `adv`=1 with data 5, then `adv`=0 with data 5, then `adv`=1 with 8, 13, 21 → `locked` rises after the 8, then 13 and 21 pass with no mismatch. A SEED idle byte of 6 instead of 5 returns to HUNT.
- Saturation and reset: with `ERR_W`=2, 5 isolated mismatches → `err_count` sticks at 3. Assert `rst` for one cycle mid-stream → all outputs take their reset values on the next edge.
